// File: rtl/adc_sum_sq_pkg.sv
// Shared defaults, accumulator width and FSM state type for the ADC sum-of-squares accumulator.
package adc_sum_sq_pkg;

  localparam int unsigned DefNSamp = 4;
  localparam int unsigned DefSampW = 8;
  localparam int unsigned DefLenW  = 16;
  localparam int unsigned AccW     = 32;

  typedef enum logic {
    StWaitSync,
    StRun
  } state_e;

endpackage

// File: rtl/adc_sum_sq_term.sv
// Three-stage square-and-sum pipeline: register inputs, square each sample, sum the squares.
// Valid and sync travel alongside so all three outputs line up with the term.
module adc_sum_sq_term
  import adc_sum_sq_pkg::*;
#(
  parameter int unsigned N_SAMP = DefNSamp,
  parameter int unsigned SAMP_W = DefSampW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_SAMP*SAMP_W-1:0]   adc_data_i,
  input  logic                       adc_valid_i,
  input  logic                       sync_i,
  output logic [2*SAMP_W:0]          term_o,
  output logic                       term_valid_o,
  output logic                       term_sync_o
);

  localparam int unsigned SqW  = 2 * SAMP_W - 1;
  localparam int unsigned SumW = 2 * SAMP_W + 1;

  logic [N_SAMP*SAMP_W-1:0]   data_q;
  logic                       valid1_q, sync1_q;
  logic [N_SAMP-1:0][SqW-1:0] sq_q, sq_d;
  logic                       valid2_q, sync2_q;
  logic [SumW-1:0]            sum_q, sum_d;
  logic                       valid3_q, sync3_q;

  logic signed [SAMP_W-1:0]   samp [N_SAMP];
  logic signed [2*SAMP_W-1:0] prod [N_SAMP];

  // A square of a SAMP_W-bit two's-complement value never needs the product's top bit.
  always_comb begin
    for (int k = 0; k < N_SAMP; k++) begin
      samp[k] = $signed(data_q[k*SAMP_W +: SAMP_W]);
      prod[k] = samp[k] * samp[k];
      sq_d[k] = SqW'(prod[k]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_SAMP; k++) begin
      sum_d = sum_d + SumW'(sq_q[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      valid1_q <= 1'b0;
      sync1_q  <= 1'b0;
      sq_q     <= '0;
      valid2_q <= 1'b0;
      sync2_q  <= 1'b0;
      sum_q    <= '0;
      valid3_q <= 1'b0;
      sync3_q  <= 1'b0;
    end else begin
      data_q   <= adc_data_i;
      valid1_q <= adc_valid_i;
      sync1_q  <= sync_i;
      sq_q     <= sq_d;
      valid2_q <= valid1_q;
      sync2_q  <= sync1_q;
      sum_q    <= sum_d;
      valid3_q <= valid2_q;
      sync3_q  <= sync2_q;
    end
  end

  assign term_o       = sum_q;
  assign term_valid_o = valid3_q;
  assign term_sync_o  = sync3_q;

endmodule

// File: rtl/adc_sum_sq_accum.sv
// Integrates the per-cycle sum of squared ADC samples over acc_len valid cycles and dumps the
// total to a 32-bit software register; sync_in (re)starts integration.
module adc_sum_sq_accum
  import adc_sum_sq_pkg::*;
#(
  parameter int unsigned N_SAMP = DefNSamp,
  parameter int unsigned SAMP_W = DefSampW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [N_SAMP*SAMP_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic                     sync_in,
  input  logic [LEN_W-1:0]         acc_len,
  output logic [AccW-1:0]          user_data_out,
  output logic                     dump_valid,
  output logic [LEN_W-1:0]         dump_count,
  output logic                     armed
);

  logic [2*SAMP_W:0] term;
  logic              term_valid;
  logic              term_sync;

  adc_sum_sq_term #(
    .N_SAMP (N_SAMP),
    .SAMP_W (SAMP_W)
  ) u_term (
    .clk_i        (user_clk),
    .rst_ni       (user_rst_n),
    .adc_data_i   (adc_data),
    .adc_valid_i  (adc_valid),
    .sync_i       (sync_in),
    .term_o       (term),
    .term_valid_o (term_valid),
    .term_sync_o  (term_sync)
  );

  state_e           state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d, acc_base;
  logic [AccW-1:0]  data_out_q, data_out_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic [LEN_W-1:0] len_q, len_d, len_base, len_new;
  logic [LEN_W-1:0] dump_count_q, dump_count_d, dump_count_base;
  logic             dump_valid_q, dump_valid_d;
  logic             accumulate;

  assign len_new = (acc_len == '0) ? LEN_W'(1) : acc_len;

  // A delayed sync first rebases the integration to empty, then the arriving term is treated
  // exactly like any other valid term; this makes sync win over a coincident terminal term.
  always_comb begin
    state_d         = state_q;
    acc_base        = acc_q;
    cnt_base        = cnt_q;
    len_base        = len_q;
    dump_count_base = dump_count_q;
    accumulate      = (state_q == StRun) && term_valid;
    if (term_sync) begin
      state_d         = StRun;
      acc_base        = '0;
      cnt_base        = '0;
      len_base        = len_new;
      dump_count_base = '0;
      accumulate      = term_valid;
    end

    cnt_inc      = cnt_base + LEN_W'(1);
    acc_d        = acc_base;
    cnt_d        = cnt_base;
    len_d        = len_base;
    dump_count_d = dump_count_base;
    data_out_d   = data_out_q;
    dump_valid_d = 1'b0;

    if (accumulate) begin
      if (cnt_inc == len_base) begin
        data_out_d   = acc_base + AccW'(term);
        dump_valid_d = 1'b1;
        dump_count_d = dump_count_base + LEN_W'(1);
        acc_d        = '0;
        cnt_d        = '0;
        len_d        = len_new;
      end else begin
        acc_d = acc_base + AccW'(term);
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= StWaitSync;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      data_out_q   <= '0;
      dump_valid_q <= 1'b0;
      dump_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      data_out_q   <= data_out_d;
      dump_valid_q <= dump_valid_d;
      dump_count_q <= dump_count_d;
    end
  end

  assign user_data_out = data_out_q;
  assign dump_valid    = dump_valid_q;
  assign dump_count    = dump_count_q;
  assign armed         = (state_q == StRun);

endmodule

// File: tb/tb_adc_sum_sq_accum.sv
// Bench for adc_sum_sq_accum: directed scenarios plus random traffic against an integer model.
module tb_adc_sum_sq_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic        sync_in;
  logic [15:0] acc_len;
  logic [31:0] user_data_out;
  logic        dump_valid;
  logic [15:0] dump_count;
  logic        armed;

  always #5 clk = ~clk;

  adc_sum_sq_accum dut (
    .user_clk      (clk),
    .user_rst_n    (rst_n),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .sync_in       (sync_in),
    .acc_len       (acc_len),
    .user_data_out (user_data_out),
    .dump_valid    (dump_valid),
    .dump_count    (dump_count),
    .armed         (armed)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_dumps  = 0;

  // Reference model: input events reach the integrator three edges after capture.
  typedef struct {
    bit     v;
    bit     s;
    longint t;
  } ev_t;

  ev_t    pq[$];
  bit     m_run;
  longint m_acc;
  longint m_out;
  int     m_cnt;
  int     m_len;
  int     m_dcnt;
  bit     m_dv;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint term_of(input logic [31:0] d);
    longint r = 0;
    for (int k = 0; k < 4; k++) begin
      int s = int'($signed(d[k*8 +: 8]));
      r += longint'(s * s);
    end
    return r;
  endfunction

  task automatic model_reset();
    ev_t z = '{v: 1'b0, s: 1'b0, t: 0};
    pq.delete();
    repeat (3) pq.push_back(z);
    m_run = 0; m_acc = 0; m_out = 0; m_cnt = 0; m_len = 0; m_dcnt = 0; m_dv = 0;
  endtask

  task automatic model_edge();
    ev_t e;
    int  nl;
    if (!rst_n) return;
    e    = pq.pop_front();
    nl   = (acc_len == 16'd0) ? 1 : int'(acc_len);
    m_dv = 0;
    if (e.s) begin
      m_run = 1; m_acc = 0; m_cnt = 0; m_dcnt = 0; m_len = nl;
    end
    if (m_run && e.v) begin
      m_cnt++;
      if (m_cnt == m_len) begin
        m_out  = m_acc + e.t;
        m_dv   = 1;
        m_dcnt = (m_dcnt + 1) % 65536;
        m_acc  = 0;
        m_cnt  = 0;
        m_len  = nl;
      end else begin
        m_acc += e.t;
      end
    end
    pq.push_back('{v: adc_valid, s: sync_in, t: term_of(adc_data)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("dump_valid", 64'(dump_valid), 64'(m_dv));
    check_eq("user_data_out", 64'(user_data_out), 64'(m_out));
    check_eq("dump_count", 64'(dump_count), 64'(m_dcnt));
    check_eq("armed", 64'(armed), 64'(m_run));
    if (dump_valid) n_dumps++;
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    sync_in   = 1'b0;
    repeat (n) cycle();
    n_dumps = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    adc_data  = '0;
    adc_valid = 1'b0;
    sync_in   = 1'b0;
    acc_len   = 16'd8;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    idle(3);

    // Constant 0x10 samples, length 8.
    adc_data = 32'h1010_1010; adc_valid = 1'b1; acc_len = 16'd8; sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (dump_valid) check_eq("r029_value", 64'(user_data_out), 64'h2000);
    end
    check_eq("r029_ndumps", 64'(n_dumps), 64'd4);

    // Full-scale negative samples over the longest integration.
    idle(4);
    adc_data = 32'h8080_8080; adc_valid = 1'b1; acc_len = 16'hFFFF; sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      cycle();
      if (dump_valid) check_eq("r030_value", 64'(user_data_out), 64'hFFFF_0000);
    end
    check_eq("r030_ndumps", 64'(n_dumps), 64'd1);

    // Samples {3,-4,0,1}, valid every other cycle.
    idle(4);
    adc_data = {8'd1, 8'd0, 8'hFC, 8'd3}; acc_len = 16'd4;
    for (int i = 0; i < 20; i++) begin
      adc_valid = (i % 2 == 0);
      sync_in   = (i == 0);
      cycle();
      if (dump_valid) check_eq("r031_value", 64'(user_data_out), 64'd104);
    end
    check_eq("r031_ndumps", 64'(n_dumps), 64'd2);

    // Restart after 5 of 8 valid cycles.
    idle(4);
    acc_len = 16'd8; adc_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      adc_data = $urandom;
      sync_in  = (i == 0 || i == 5);
      cycle();
    end
    check_eq("r032_ndumps", 64'(n_dumps), 64'd2);

    // Reset mid-integration, then data with no sync.
    idle(4);
    acc_len = 16'd8; adc_valid = 1'b1; sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    repeat (4) cycle();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
    n_dumps = 0;
    for (int i = 0; i < 20; i++) begin
      adc_data = $urandom;
      cycle();
    end
    check_eq("r033_ndumps", 64'(n_dumps), 64'd0);
    check_eq("r033_armed", 64'(armed), 64'd0);
    check_eq("r033_data", 64'(user_data_out), 64'd0);

    // Zero length dumps every valid cycle.
    idle(4);
    acc_len = 16'd0; adc_valid = 1'b1; sync_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      adc_data = $urandom;
      cycle();
      sync_in = 1'b0;
    end
    check_eq("r034_len0_ndumps", 64'(n_dumps), 64'd7);

    // Length change 8 -> 4 during an integration.
    idle(4);
    acc_len = 16'd8; adc_valid = 1'b1; sync_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      adc_data = $urandom;
      if (i == 4) acc_len = 16'd4;
      cycle();
      sync_in = 1'b0;
    end
    check_eq("r034_change_ndumps", 64'(n_dumps), 64'd5);

    // Random traffic with occasional sync, length changes and resets.
    idle(4);
    acc_len = 16'd3;
    for (int i = 0; i < 3000; i++) begin
      adc_data  = $urandom;
      adc_valid = ($urandom_range(0, 9) < 7);
      sync_in   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) acc_len = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
